// File: rtl/mux_pkt_arbiter.sv
// Packet arbiter for a 2:1 router output mux: grants on HEAD, holds the grant until TAIL
// is accepted, alternates round-robin between packets and force-releases a stalled lock.
module mux_pkt_arbiter #(
  parameter int              TYPEW     = 2,
  parameter logic [TYPEW-1:0] TYPE_HEAD = 2'b01,
  parameter logic [TYPEW-1:0] TYPE_DATA = 2'b10,
  parameter logic [TYPEW-1:0] TYPE_TAIL = 2'b11,
  parameter int              TIMEOUT   = 16,
  parameter int              CNTW      = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             ordy,
  output logic [1:0]       sel,
  output logic             ack_0,
  output logic             ack_1,
  output logic             busy,
  output logic             tout
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT == 0) ? {CNTW{1'b0}} : CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_r, state_s;
  logic            grant_r, grant_s;
  logic            rr_r, rr_s;
  logic [CNTW-1:0] cnt_r, cnt_s;
  logic [1:0]      sel_s;
  logic            busy_s, tout_s;

  logic             cand_0_s, cand_1_s;
  logic             ivalid_g_s, ack_g_s;
  logic [TYPEW-1:0] itype_g_s, ftype_g_s;

  // Granted-port view and combinational flit acceptance.
  always_comb begin
    cand_0_s   = ivalid_0 & (itype_0 == TYPE_HEAD);
    cand_1_s   = ivalid_1 & (itype_1 == TYPE_HEAD);
    ivalid_g_s = grant_r ? ivalid_1 : ivalid_0;
    itype_g_s  = grant_r ? itype_1 : itype_0;
    // A repeated HEAD inside a locked packet is just payload.
    if (itype_g_s == TYPE_HEAD) begin
      ftype_g_s = TYPE_DATA;
    end else begin
      ftype_g_s = itype_g_s;
    end
    ack_g_s = (state_r == LOCK) & ivalid_g_s & ordy;
  end

  assign ack_0 = ack_g_s & ~grant_r;
  assign ack_1 = ack_g_s &  grant_r;

  // Next-state, grant, round-robin pointer, stall counter and registered outputs.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    rr_s    = rr_r;
    cnt_s   = cnt_r;
    sel_s   = sel;
    busy_s  = busy;
    tout_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = {CNTW{1'b0}};
        if (cand_0_s | cand_1_s) begin
          grant_s = (cand_0_s & cand_1_s) ? rr_r : cand_1_s;
          state_s = LOCK;
          sel_s   = grant_s ? 2'b10 : 2'b01;
          busy_s  = 1'b1;
        end else begin
          sel_s  = 2'b00;
          busy_s = 1'b0;
        end
      end
      LOCK: begin
        if (ack_g_s) begin
          cnt_s = {CNTW{1'b0}};
          if (ftype_g_s == TYPE_TAIL) begin
            state_s = IDLE;
            sel_s   = 2'b00;
            busy_s  = 1'b0;
            rr_s    = ~grant_r;
          end else begin
            state_s = LOCK;
          end
        end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
          state_s = IDLE;
          sel_s   = 2'b00;
          busy_s  = 1'b0;
          rr_s    = ~grant_r;
          cnt_s   = {CNTW{1'b0}};
          tout_s  = 1'b1;
        end else if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        sel_s   = 2'b00;
        busy_s  = 1'b0;
        cnt_s   = {CNTW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_r <= IDLE;
      grant_r <= 1'b0;
      rr_r    <= 1'b0;
      cnt_r   <= {CNTW{1'b0}};
      sel     <= 2'b00;
      busy    <= 1'b0;
      tout    <= 1'b0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      rr_r    <= rr_s;
      cnt_r   <= cnt_s;
      sel     <= sel_s;
      busy    <= busy_s;
      tout    <= tout_s;
    end
  end

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Directed bench for mux_pkt_arbiter (TIMEOUT=8): single-port packet, round-robin,
// downstream stall, timeout release, mid-packet reset and non-HEAD flits in IDLE.
module tb_mux_pkt_arbiter;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] DATA = 2'b10;
  localparam logic [1:0] TAIL = 2'b11;

  logic       clk = 1'b0;
  logic       rst_;
  logic       ivalid_0, ivalid_1, ordy;
  logic [1:0] itype_0, itype_1;
  logic [1:0] sel;
  logic       ack_0, ack_1, busy, tout;

  int checks   = 0;
  int failures = 0;

  mux_pkt_arbiter #(.TIMEOUT(8), .CNTW(8)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy), .sel(sel), .ack_0(ack_0), .ack_1(ack_1),
    .busy(busy), .tout(tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // let combinational acks settle after input changes
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_ = 1'b0; ivalid_0 = 1'b0; ivalid_1 = 1'b0;
    itype_0 = 2'b00; itype_1 = 2'b00; ordy = 1'b1;
    cyc(); cyc();
    chk("rst_sel", {6'd0, sel}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_tout", {7'd0, tout}, 8'h00);
    chk("rst_ack", {6'd0, ack_1, ack_0}, 8'h00);
    rst_ = 1'b1;

    // 1: port-1-only packet, HEAD + 20 DATA + TAIL with ordy high
    ivalid_1 = 1'b1; itype_1 = HEAD; settle();
    chk("t1_idle_ack1", {7'd0, ack_1}, 8'h00);
    cyc();
    chk("t1_sel_grant", {6'd0, sel}, 8'h02);
    chk("t1_busy", {7'd0, busy}, 8'h01);
    settle();
    chk("t1_head_ack1", {7'd0, ack_1}, 8'h01);
    for (int i = 0; i < 20; i++) begin
      cyc();
      itype_1 = DATA; settle();
      chk("t1_data_ack1", {7'd0, ack_1}, 8'h01);
      chk("t1_data_sel", {6'd0, sel}, 8'h02);
    end
    cyc();
    itype_1 = TAIL; settle();
    chk("t1_tail_ack1", {7'd0, ack_1}, 8'h01);
    cyc();
    ivalid_1 = 1'b0;
    chk("t1_release_sel", {6'd0, sel}, 8'h00);
    chk("t1_release_busy", {7'd0, busy}, 8'h00);

    // 2: both HEADs; rr pointer is 0 after port-1 release -> port 0 first
    ivalid_0 = 1'b1; itype_0 = HEAD; ivalid_1 = 1'b1; itype_1 = HEAD; settle();
    chk("t2_idle_acks", {6'd0, ack_1, ack_0}, 8'h00);
    cyc();
    chk("t2_sel_p0", {6'd0, sel}, 8'h01);
    settle();
    chk("t2_p0_head_acks", {6'd0, ack_1, ack_0}, 8'h01);
    cyc();
    itype_0 = TAIL; settle();
    chk("t2_p0_tail_acks", {6'd0, ack_1, ack_0}, 8'h01);
    cyc();
    ivalid_0 = 1'b0;
    chk("t2_bubble_sel", {6'd0, sel}, 8'h00);
    settle();
    chk("t2_bubble_acks", {6'd0, ack_1, ack_0}, 8'h00);
    cyc();
    chk("t2_sel_p1", {6'd0, sel}, 8'h02);
    settle();
    chk("t2_p1_head_acks", {6'd0, ack_1, ack_0}, 8'h02);
    cyc();
    itype_1 = TAIL; settle();
    chk("t2_p1_tail_acks", {6'd0, ack_1, ack_0}, 8'h02);
    cyc();
    ivalid_0 = 1'b1; itype_0 = HEAD; itype_1 = HEAD;
    chk("t2_bubble2_sel", {6'd0, sel}, 8'h00);
    cyc();
    chk("t2_alt_sel_p0", {6'd0, sel}, 8'h01);
    settle();
    chk("t2_alt_head_ack0", {7'd0, ack_0}, 8'h01);

    // 3: downstream stall for 3 cycles inside port-0 packet
    cyc();
    itype_0 = DATA; ordy = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_ack0", {7'd0, ack_0}, 8'h00);
      chk("t3_stall_sel", {6'd0, sel}, 8'h01);
      chk("t3_stall_tout", {7'd0, tout}, 8'h00);
      cyc();
    end
    ordy = 1'b1; settle();
    chk("t3_resume_ack0", {7'd0, ack_0}, 8'h01);

    // 4: port 0 goes silent after that ack -> timeout release after 8 idle cycles
    for (int i = 0; i < 8; i++) begin
      cyc();
      ivalid_0 = 1'b0;
      chk("t4_pre_tout", {7'd0, tout}, 8'h00);
      chk("t4_pre_sel", {6'd0, sel}, 8'h01);
    end
    cyc();
    chk("t4_tout", {7'd0, tout}, 8'h01);
    chk("t4_tout_sel", {6'd0, sel}, 8'h00);
    chk("t4_tout_busy", {7'd0, busy}, 8'h00);
    ivalid_0 = 1'b1; itype_0 = HEAD;
    cyc();
    chk("t4_tout_pulse_end", {7'd0, tout}, 8'h00);
    chk("t4_after_sel_p1", {6'd0, sel}, 8'h02);

    // 5: reset in LOCK, then both HEADs go to port 0
    rst_ = 1'b0;
    cyc();
    chk("t5_rst_sel", {6'd0, sel}, 8'h00);
    chk("t5_rst_busy", {7'd0, busy}, 8'h00);
    settle();
    chk("t5_rst_acks", {6'd0, ack_1, ack_0}, 8'h00);
    rst_ = 1'b1;
    cyc();
    chk("t5_regrant_p0", {6'd0, sel}, 8'h01);

    // 6: DATA flit on port 0 in IDLE is never granted or acked
    rst_ = 1'b0; ivalid_1 = 1'b0;
    cyc();
    rst_ = 1'b1; ivalid_0 = 1'b1; itype_0 = DATA;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t6_ack0", {7'd0, ack_0}, 8'h00);
      cyc();
      chk("t6_sel", {6'd0, sel}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
